poly_eval: RTL and testbench

Parametrised sequential polynomial evaluator using Horner's rule: computes result = c[N]·x^N + … + c[1]·x + c[0] with one multiply-accumulate per clock under a start/done handshake. This is the successor to the fixed second-order a·x²+b·x+c resolver. It generalises degree and operand widths, adds a busy indication and operand capture, and optionally adds an overflow flag. It sits as a leaf compute block behind any controller that drives start and waits on done.

---
 rtl/poly_pkg.sv | 25 ++
 rtl/poly_datapath.sv | 87 ++++++++
 rtl/poly_eval.sv | 89 ++++++++
 tb/tb_poly_eval.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/poly_pkg.sv
// Shared types, default widths and helpers for the Horner polynomial evaluator.
package poly_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    // Per-cycle strobes from the FSM to the datapath
    typedef struct packed {
        logic load;
        logic step;
    } dp_ctrl_t;

    localparam int unsigned DEF_XW     = 9;
    localparam int unsigned DEF_RW     = 17;
    localparam int unsigned DEF_DEGREE = 2;

    // Width of the coefficient index counter, never narrower than one bit
    function automatic int unsigned idx_width(input int unsigned degree);
        return (degree > 0) ? $clog2(degree + 1) : 1;
    endfunction

endpackage

// File: rtl/poly_datapath.sv
// Operand capture, accumulator and one multiply-add per step for Horner evaluation.
// Optional overflow detection is built when POLY_OVF_FLAG_EN is defined.
module poly_datapath
    import poly_pkg::*;
#(
    parameter int unsigned XW     = DEF_XW,
    parameter int unsigned RW     = DEF_RW,
    parameter int unsigned DEGREE = DEF_DEGREE
) (
    input  logic                       clk,
    input  logic                       reset,
    input  dp_ctrl_t                   ctrl,
    input  logic [XW-1:0]              x,
    input  logic [(DEGREE+1)*RW-1:0]   coef,
    output logic [RW-1:0]              acc,
`ifdef POLY_OVF_FLAG_EN
    output logic                       ovf,
`endif
    output logic                       idx_zero_c
);

    localparam int unsigned IW = idx_width(DEGREE);
    localparam int unsigned PW = RW + XW;
    localparam logic [IW-1:0] IDX_INIT = (DEGREE > 0) ? IW'(DEGREE - 1) : '0;

    logic [XW-1:0] x_q;
    logic [RW-1:0] coef_q  [DEGREE+1];
    logic [RW-1:0] coef_in [DEGREE+1];
    logic [IW-1:0] idx;
    logic [RW-1:0] c_top;
    logic [RW-1:0] c_sel;
    logic [RW-1:0] acc_next;

    // Unpack the flattened coefficient bus into one word per term
    for (genvar g = 0; g < DEGREE + 1; g++) begin : g_unpack
        assign coef_in[g] = coef[g*RW +: RW];
    end

    assign c_top      = coef[DEGREE*RW +: RW];
    assign c_sel      = coef_q[idx];
    assign idx_zero_c = (idx == '0);

`ifdef POLY_OVF_FLAG_EN
    logic [PW-1:0] prod_c;
    logic [RW:0]   sum_c;
    logic          step_ovf;

    // Full-width product so discarded upper bits and the add carry can be flagged
    assign prod_c   = PW'(acc) * PW'(x_q);
    assign sum_c    = {1'b0, prod_c[RW-1:0]} + {1'b0, c_sel};
    assign acc_next = sum_c[RW-1:0];
    assign step_ovf = (|prod_c[PW-1:RW]) | sum_c[RW];
`else
    logic [RW-1:0] prod_c;

    // Only the low RW bits of the product ever reach the accumulator
    assign prod_c   = RW'(PW'(acc) * PW'(x_q));
    assign acc_next = prod_c + c_sel;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            x_q    <= '0;
            coef_q <= '{default: '0};
            acc    <= '0;
            idx    <= '0;
`ifdef POLY_OVF_FLAG_EN
            ovf    <= 1'b0;
`endif
        end else if (ctrl.load) begin
            x_q    <= x;
            coef_q <= coef_in;
            acc    <= c_top;
            idx    <= IDX_INIT;
`ifdef POLY_OVF_FLAG_EN
            ovf    <= 1'b0;
`endif
        end else if (ctrl.step) begin
            acc    <= acc_next;
            idx    <= idx - IW'(1);
`ifdef POLY_OVF_FLAG_EN
            ovf    <= ovf | step_ovf;
`endif
        end
    end

endmodule

// File: rtl/poly_eval.sv
// Sequential Horner polynomial evaluator: start/done handshake around poly_datapath.
// Defining POLY_OVF_FLAG_EN adds the sticky ovf output.
module poly_eval
    import poly_pkg::*;
#(
    parameter int unsigned XW     = DEF_XW,
    parameter int unsigned RW     = DEF_RW,
    parameter int unsigned DEGREE = DEF_DEGREE
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       start,
    input  logic [XW-1:0]              x,
    input  logic [(DEGREE+1)*RW-1:0]   coef,
    output logic [RW-1:0]              result,
    output logic                       done,
    output logic                       busy
`ifdef POLY_OVF_FLAG_EN
    ,
    output logic                       ovf
`endif
);

    state_t   state;
    state_t   state_d;
    dp_ctrl_t ctrl_c;
    logic     done_d;
    logic     busy_d;
    logic     idx_zero_c;

    // State and handshake outputs are all registered
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            done  <= 1'b0;
            busy  <= 1'b0;
        end else begin
            state <= state_d;
            done  <= done_d;
            busy  <= busy_d;
        end
    end

    // Next state, datapath strobes and next-cycle handshake values
    always_comb begin
        state_d = state;
        ctrl_c  = '0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    ctrl_c.load = 1'b1;
                    state_d     = (DEGREE == 0) ? DONE : CALC;
                end
            end
            CALC: begin
                ctrl_c.step = 1'b1;
                if (idx_zero_c) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        done_d = (state_d == DONE);
        busy_d = (state_d != IDLE);
    end

    poly_datapath #(
        .XW     (XW),
        .RW     (RW),
        .DEGREE (DEGREE)
    ) u_datapath (
        .clk        (clk),
        .reset      (reset),
        .ctrl       (ctrl_c),
        .x          (x),
        .coef       (coef),
        .acc        (result),
`ifdef POLY_OVF_FLAG_EN
        .ovf        (ovf),
`endif
        .idx_zero_c (idx_zero_c)
    );

endmodule

// File: tb/tb_poly_eval.sv
// Self-checking bench for poly_eval: transaction-level polynomial model plus directed cases.
module tb_poly_eval;

    localparam int unsigned XW  = 9;
    localparam int unsigned RW  = 17;
    localparam int unsigned DEG = 2;
    localparam int unsigned CW  = (DEG + 1) * RW;

    localparam logic [CW-1:0] C39  = {17'd2, 17'd1, 17'd3};
    localparam logic [CW-1:0] CBIG = {17'd4, 17'd0, 17'd0};
    localparam logic [CW-1:0] C13  = {17'd1, 17'd1, 17'd1};

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [XW-1:0] x;
    logic [CW-1:0] coef;
    logic [RW-1:0] result;
    logic          done;
    logic          busy;

    logic          start0;
    logic [XW-1:0] x0;
    logic [RW-1:0] coef0;
    logic [RW-1:0] result0;
    logic          done0;
    logic          busy0;

`ifdef POLY_OVF_FLAG_EN
    logic ovf;
    logic ovf0;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    poly_eval #(.XW(XW), .RW(RW), .DEGREE(DEG)) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .x      (x),
        .coef   (coef),
        .result (result),
`ifdef POLY_OVF_FLAG_EN
        .ovf    (ovf),
`endif
        .done   (done),
        .busy   (busy)
    );

    poly_eval #(.XW(XW), .RW(RW), .DEGREE(0)) dut0 (
        .clk    (clk),
        .reset  (reset),
        .start  (start0),
        .x      (x0),
        .coef   (coef0),
        .result (result0),
`ifdef POLY_OVF_FLAG_EN
        .ovf    (ovf0),
`endif
        .done   (done0),
        .busy   (busy0)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Value of the polynomial as a plain sum of c[i]*x^i, modulo 2^RW
    function automatic logic [RW-1:0] poly_ref(input logic [XW-1:0] xv, input logic [CW-1:0] cv);
        longint unsigned m  = 64'd1 << RW;
        longint unsigned xp = 1;
        longint unsigned s  = 0;
        longint unsigned c;
        for (int i = 0; i <= int'(DEG); i++) begin
            c  = longint'(cv[i*RW +: RW]);
            s  = (s + c * xp) % m;
            xp = (xp * longint'(xv)) % m;
        end
        return RW'(s);
    endfunction

    // Overflow: any Horner step whose product or sum leaves the RW-bit range
    function automatic bit ovf_ref(input logic [XW-1:0] xv, input logic [CW-1:0] cv);
        longint unsigned m = 64'd1 << RW;
        longint unsigned a = longint'(cv[DEG*RW +: RW]);
        longint unsigned p;
        bit o = 1'b0;
        for (int i = int'(DEG) - 1; i >= 0; i--) begin
            p = a * longint'(xv);
            if (p >= m) o = 1'b1;
            a = (p % m) + longint'(cv[i*RW +: RW]);
            if (a >= m) o = 1'b1;
            a = a % m;
        end
        return o;
    endfunction

    // Transaction model: cycles of busy left, and the value expected at completion
    int            cnt     = 0;
    logic [RW-1:0] exp_res = '0;
    bit            exp_ovf = 1'b0;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt     = 0;
            exp_res = '0;
            exp_ovf = 1'b0;
        end else if (cnt == 0) begin
            if (start === 1'b1) begin
                cnt     = int'(DEG) + 1;
                exp_res = poly_ref(x, coef);
                exp_ovf = ovf_ref(x, coef);
            end
        end else begin
            cnt = cnt - 1;
        end
    end

    // Every cycle: handshake always, result/ovf whenever they are meant to be stable
    always @(negedge clk) begin
        check("cyc_busy", 64'(busy), 64'(cnt > 0));
        check("cyc_done", 64'(done), 64'(cnt == 1));
        if (cnt <= 1) begin
            check("cyc_result", 64'(result), 64'(exp_res));
`ifdef POLY_OVF_FLAG_EN
            check("cyc_ovf", 64'(ovf), 64'(exp_ovf));
`endif
        end
    end

    // Pulse start for one cycle, then wait (bounded) for done
    task automatic pulse_and_wait(input logic [XW-1:0] xv, input logic [CW-1:0] cv,
                                  output int lat, output int busy_cyc);
        x        = xv;
        coef     = cv;
        start    = 1'b1;
        lat      = 0;
        busy_cyc = 0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            start = 1'b0;
            if (busy) busy_cyc++;
            if (done) begin
                lat = i;
                break;
            end
        end
    endtask

    initial begin
        int lat;
        int bc;
        int ndone;
        int last_pos;
        logic [RW-1:0] seen_res;

        reset  = 1'b0;
        start  = 1'b0;
        x      = '0;
        coef   = '0;
        start0 = 1'b0;
        x0     = '0;
        coef0  = '0;
        repeat (2) @(negedge clk);

        check("rst_result", 64'(result), 64'd0);
        check("rst_busy",   64'(busy),   64'd0);
        check("rst_done",   64'(done),   64'd0);
        check("rst_result0", 64'(result0), 64'd0);

        check("model_39", 64'(poly_ref(9'd4, C39)), 64'd39);
        check("model_wrap", 64'(poly_ref(9'd256, CBIG)), 64'd0);
        check("model_13", 64'(poly_ref(9'd3, C13)), 64'd13);
        check("model_ovf_wrap", 64'(ovf_ref(9'd256, CBIG)), 64'd1);
        check("model_ovf_39", 64'(ovf_ref(9'd4, C39)), 64'd0);

        reset = 1'b1;

        // Basic evaluation, first edge after reset release accepts start
        pulse_and_wait(9'd4, C39, lat, bc);
        check("t1_latency", 64'(lat), 64'd3);
        check("t1_busy_cycles", 64'(bc), 64'd3);
        check("t1_result", 64'(result), 64'd39);
`ifdef POLY_OVF_FLAG_EN
        check("t1_ovf", 64'(ovf), 64'd0);
`endif
        @(negedge clk);
        check("t1_done_single", 64'(done), 64'd0);
        check("t1_result_held", 64'(result), 64'd39);
        repeat (2) @(negedge clk);

        // Truncated product wraps to zero
        pulse_and_wait(9'd256, CBIG, lat, bc);
        check("t2_latency", 64'(lat), 64'd3);
        check("t2_result", 64'(result), 64'd0);
`ifdef POLY_OVF_FLAG_EN
        check("t2_ovf", 64'(ovf), 64'd1);
`endif
        repeat (2) @(negedge clk);

        // Degree-zero instance completes the cycle after acceptance
        coef0  = 17'h1ABCD;
        x0     = 9'd77;
        start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        check("t3_done0", 64'(done0), 64'd1);
        check("t3_busy0", 64'(busy0), 64'd1);
        check("t3_result0", 64'(result0), 64'h1ABCD);
        @(negedge clk);
        check("t3_done0_off", 64'(done0), 64'd0);
        check("t3_busy0_off", 64'(busy0), 64'd0);
        check("t3_result0_held", 64'(result0), 64'h1ABCD);
        repeat (2) @(negedge clk);

        // start and operands changing mid-evaluation are ignored
        x     = 9'd4;
        coef  = C39;
        start = 1'b1;
        @(negedge clk);
        x     = 9'd7;
        coef  = CW'({$urandom(), $urandom()});
        start = 1'b1;
        @(negedge clk);
        start    = 1'b0;
        ndone    = 0;
        seen_res = '0;
        for (int i = 0; i < 8; i++) begin
            if (done) begin
                ndone++;
                seen_res = result;
            end
            @(negedge clk);
        end
        check("t4_done_count", 64'(ndone), 64'd1);
        check("t4_result", 64'(seen_res), 64'd39);

        // start held high: back-to-back evaluations every DEG+2 cycles
        x        = 9'd4;
        coef     = C39;
        start    = 1'b1;
        ndone    = 0;
        last_pos = -1;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (done) begin
                ndone++;
                check("t5_result", 64'(result), 64'd39);
                if (last_pos >= 0) check("t5_interval", 64'(i - last_pos), 64'd4);
                last_pos = i;
            end
        end
        start = 1'b0;
        check("t5_done_count", 64'(ndone), 64'd5);
        repeat (3) @(negedge clk);

        // Asynchronous reset in the middle of CALC
        x     = 9'd5;
        coef  = C39;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        #2;
        reset = 1'b0;
        #1;
        check("t6_rst_result", 64'(result), 64'd0);
        check("t6_rst_busy",   64'(busy),   64'd0);
        check("t6_rst_done",   64'(done),   64'd0);
`ifdef POLY_OVF_FLAG_EN
        check("t6_rst_ovf",    64'(ovf),    64'd0);
`endif
        @(negedge clk);
        reset = 1'b1;
        pulse_and_wait(9'd3, C13, lat, bc);
        check("t6_latency", 64'(lat), 64'd3);
        check("t6_result", 64'(result), 64'd13);
        repeat (2) @(negedge clk);

        // Random traffic against the model, including extreme x values
        for (int i = 0; i < 300; i++) begin
            start = ($urandom_range(0, 3) != 0);
            x     = XW'($urandom());
            if ($urandom_range(0, 7) == 0) x = '1;
            if ($urandom_range(0, 7) == 0) x = '0;
            coef  = CW'({$urandom(), $urandom()});
            if ($urandom_range(0, 9) == 0) coef = '1;
            @(negedge clk);
        end
        start = 1'b0;
        repeat (6) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d failures=%0d", n_checks, n_fail);
        $fatal(1, "timeout");
    end

endmodule
